// File: rtl/puzzle_loader.sv
// Serial Sudoku puzzle loader: turns a row-major stream of N*N digits into
// per-cell load strobes and reports completion, error and given count.
module puzzle_loader #(
  parameter int         N        = 9,
  parameter logic [3:0] CMD_LOAD = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] in_digit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] cmd,
  output logic [3:0] data_out,
  output logic       data_out_rdy,
  output logic [3:0] cell_x,
  output logic [3:0] cell_y,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [6:0] givens
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam logic [3:0] NV  = 4'(N);
  localparam logic [3:0] NM1 = 4'(N - 1);

  state_t     state;
  logic [3:0] x, y;
  logic       xfer;
  logic       illegal;

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD) || (state == DRAIN);
  assign done     = (state == DONE);
  assign xfer     = in_valid && in_ready;
  assign illegal  = (in_digit > NV);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      cmd          <= '0;
      data_out     <= '0;
      data_out_rdy <= 1'b0;
      cell_x       <= '0;
      cell_y       <= '0;
      error        <= 1'b0;
      givens       <= '0;
    end else begin
      // Strobe lasts exactly one cycle; only a LOAD transfer re-arms it.
      data_out_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x      <= '0;
            y      <= '0;
            givens <= '0;
            error  <= 1'b0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            data_out     <= illegal ? 4'd0 : in_digit;
            cell_x       <= x;
            cell_y       <= y;
            cmd          <= CMD_LOAD;
            data_out_rdy <= 1'b1;
            if (illegal)
              error <= 1'b1;
            else if (in_digit != 4'd0)
              givens <= givens + 7'd1;
            if (x == NM1) begin
              x <= '0;
              if (y == NM1) state <= DRAIN;
              else          y     <= y + 4'd1;
            end else begin
              x <= x + 4'd1;
            end
          end
        end
        DRAIN:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/puzzle_loader.md
# puzzle_loader

Upstream feeder for the 9x9 array of Sudoku cells. Accepts a puzzle as a serial stream of 81 four-bit digits (row-major, 0 = empty) over a valid/ready handshake. Converts each digit into a load command addressed to one cell (`cmd` = 0, `data_out`, write strobe plus x/y select), then reports completion, an error flag, and the number of givens.

## Interface
Parameters:
- `N`, 9: grid side; stream length is N*N.
- `CMD_LOAD`, 4'd0: command code driven on `cmd` during a load strobe.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to begin loading; honoured only in IDLE.
- `in_digit`  in  4  incoming digit.
- `in_valid`  in  1  `in_digit` valid.
- `in_ready`  out  1  loader accepts a digit this cycle; transfer = `in_valid & in_ready`.
- `cmd`  out  4  command to cells; broadcast.
- `data_out`  out  4  digit to cells; drives cell `data_in`.
- `data_out_rdy`  out  1  write strobe; drives the addressed cell's `data_in_rdy`.
- `cell_x`  out  4  column of the addressed cell, 0..N-1.
- `cell_y`  out  4  row of the addressed cell, 0..N-1.
- `busy`  out  1  high in LOAD and DRAIN.
- `done`  out  1  one-cycle pulse when the final strobe has been issued.
- `error`  out  1  sticky; set on any digit > N in the current load.
- `givens`  out  7  count of non-zero legal digits accepted in the current load, 0..81.

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE: `in_ready`=0, `busy`=0. On `start`: clear x, y, `givens`, `error`; go to LOAD.
- LOAD: `in_ready`=1, decoded combinationally from state. On each transfer:
  - Register `data_out` = digit, or 0 if digit > N.
  - Register `cell_x`/`cell_y` = current x/y.
  - Set `cmd` = CMD_LOAD and `data_out_rdy` = 1 for the next cycle.
  - If the digit is 1..N, increment `givens`.
  - If the digit > N, set `error`; the cell is still written with 0.
  - Advance x. When x = N-1, wrap x to 0 and increment y.
  - Transfer at x = N-1, y = N-1 (81st digit) → DRAIN.
- No transfer in LOAD: `data_out_rdy` = 0. `cmd`, `data_out`, `cell_x` and `cell_y` hold their last values.
- DRAIN: one cycle; the final strobe is on the outputs; `in_ready` = 0 → DONE.
- DONE: `done` = 1 for one cycle, `data_out_rdy` = 0 → IDLE.
- `start` in LOAD/DRAIN/DONE: ignored.
- `start` is never accepted together with a digit: `in_ready` = 0 in IDLE, so a digit presented in the `start` cycle is not consumed.
- `error` and `givens` hold after DONE until the next accepted `start` or `rst`.
- Width rules: `givens` saturates by construction at 81 (7 bits). x and y never exceed N-1.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`, `data_out_rdy`, `busy`, `done`, `error` = 0.
  - `cmd`, `data_out`, `cell_x`, `cell_y` = 0.
  - `givens` = 0.
- `start` at cycle t → `in_ready` = 1 at t+1.
- Transfer at cycle k → `data_out_rdy` = 1 with matching `cell_x`/`cell_y`/`data_out` during cycle k+1 only. Latency is 1; throughput is 1 digit/cycle.
- Consecutive transfers give back-to-back strobes with no bubble.
- 81st transfer at k:
  - Final strobe at k+1 (DRAIN).
  - `done` at k+2.
  - `busy` falls at k+2.
  - `in_ready` = 0 from k+1.
- Minimum load time with no stalls: `start` at t → `done` at t+83.
- `rst` mid-load: next cycle in IDLE with all reset values. No strobe is issued for a digit presented in the reset cycle. The partial load is abandoned; the cells keep what was already written.

## Test plan
- **Full puzzle:** `start`, then 81 back-to-back digits with 30 non-zero.
  - Expect 81 strobes with coordinates (0,0)..(8,8) row-major and `data_out` matching the input.
  - Expect `givens` = 30, `error` = 0, `done` exactly 83 cycles after `start`.
- **Backpressure bubbles:** random `in_valid` gaps (~50%).
  - Strobe count is 81, each strobe exactly 1 cycle after its transfer.
  - No strobe during gaps; outputs hold their values.
- **Illegal digit:** digit 12 at stream index 5 (x=5, y=0).
  - Strobe at (5,0) with `data_out` = 0.
  - `error` rises the cycle after the transfer and stays 1 through DONE.
  - `givens` excludes it.
- **Reset mid-load:** assert `rst` after 40 transfers.
  - Next cycle: IDLE, `in_ready` = 0, `busy` = 0, `givens` = 0, no further strobes.
  - A new `start` reloads from (0,0).
- **Start misuse:**
  - `start` pulses during LOAD at transfer 20 → no counter reset; the load completes normally.
  - `start` in the same cycle as `in_valid` in IDLE → digit not accepted (`in_ready` = 0).
- **Row wrap:** after transfer at (8,0), the next strobe is at (0,1). After transfer at (8,8), no further `in_ready` and `done` follows after one cycle.
